data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder_lane_align.sv | 56 +++++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access-size encodings,
// FSM state encoding and the access legality helper.
package data_mem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // True when the size code is illegal or the byte offset is not
    // naturally aligned for that size.
    function automatic logic access_illegal(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a datapath (master) and the data memory
// responder (slave).
interface data_mem_responder_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqSigned, RespReady,
        input  ReqReady, RespValid, RespRData, RespErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqSigned, RespReady,
        output ReqReady, RespValid, RespRData, RespErr
    );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Big-endian byte-lane steering: offset 0 is the most significant byte.
// Produces the extended load value, the byte-enable mask and the store word
// positioned in its lanes. Purely combinational.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] raw_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  byte_shift_s;
    logic [4:0]  half_shift_s;
    logic [31:0] byte_raw_s;
    logic [31:0] half_raw_s;

    assign byte_shift_s = {2'd3 - off_i, 3'b000};
    assign half_shift_s = off_i[1] ? 5'd0 : 5'd16;
    assign byte_raw_s   = raw_word_i >> byte_shift_s;
    assign half_raw_s   = raw_word_i >> half_shift_s;

    // Select lanes for the access size and extend loads.
    always_comb begin
        load_data_o  = 32'h0000_0000;
        byte_en_o    = 4'b0000;
        store_word_o = 32'h0000_0000;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o  = {{24{signed_i & byte_raw_s[7]}}, byte_raw_s[7:0]};
                byte_en_o    = 4'b1000 >> off_i;
                store_word_o = {24'h00_0000, store_data_i[7:0]} << byte_shift_s;
            end
            SIZE_HALF: begin
                load_data_o  = {{16{signed_i & half_raw_s[15]}}, half_raw_s[15:0]};
                byte_en_o    = off_i[1] ? 4'b0011 : 4'b1100;
                store_word_o = {16'h0000, store_data_i[15:0]} << half_shift_s;
            end
            SIZE_WORD: begin
                load_data_o  = raw_word_i;
                byte_en_o    = 4'b1111;
                store_word_o = store_data_i;
            end
            default: begin
                load_data_o  = 32'h0000_0000;
                byte_en_o    = 4'b0000;
                store_word_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with configurable wait states.
// A request is captured in IDLE, optionally held for WAIT_STATES cycles, and
// the memory access (store commit or load read) happens on the edge that
// enters RESP. The response is held until the datapath consumes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    data_mem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        accept_s;
    logic        commit_s;

    logic        req_write_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [1:0]  req_size_q;
    logic        req_signed_q;
    logic        resp_err_q;

    logic        cur_write_s;
    logic [31:0] cur_addr_s;
    logic [31:0] cur_wdata_s;
    logic [1:0]  cur_size_s;
    logic        cur_signed_s;
    logic        err_s;
    logic [AW-1:0] word_idx_s;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] raw_q;

    logic [31:0] load_data_s;
    logic [3:0]  byte_en_s;
    logic [31:0] store_word_s;

    // With zero wait states the access commits on the accept edge, so the
    // live bus fields are used in IDLE and the captured copy afterwards.
    assign cur_write_s  = (state_q == ST_IDLE) ? bus.ReqWrite  : req_write_q;
    assign cur_addr_s   = (state_q == ST_IDLE) ? bus.ReqAddr   : req_addr_q;
    assign cur_wdata_s  = (state_q == ST_IDLE) ? bus.ReqWData  : req_wdata_q;
    assign cur_size_s   = (state_q == ST_IDLE) ? bus.ReqSize   : req_size_q;
    assign cur_signed_s = (state_q == ST_IDLE) ? bus.ReqSigned : req_signed_q;

    assign word_idx_s = cur_addr_s[AW+1:2];
    assign err_s      = access_illegal(cur_size_s, cur_addr_s[1:0])
                      | (|cur_addr_s[31:AW+2]);

    mem_lane_align u_align (
        .off_i        (cur_addr_s[1:0]),
        .size_i       (cur_size_s),
        .signed_i     (cur_signed_s),
        .raw_word_i   (raw_q),
        .store_data_i (cur_wdata_s),
        .load_data_o  (load_data_s),
        .byte_en_o    (byte_en_s),
        .store_word_o (store_word_s)
    );

    // Next-state logic; requests are refused while reset is held.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ReqValid && Rst) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.RespReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Capture the request on accept and the error flag on commit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            req_write_q  <= 1'b0;
            req_addr_q   <= 32'h0000_0000;
            req_wdata_q  <= 32'h0000_0000;
            req_size_q   <= SIZE_BYTE;
            req_signed_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                req_write_q  <= bus.ReqWrite;
                req_addr_q   <= bus.ReqAddr;
                req_wdata_q  <= bus.ReqWData;
                req_size_q   <= bus.ReqSize;
                req_signed_q <= bus.ReqSigned;
            end
            if (commit_s) begin
                resp_err_q <= err_s;
            end
        end
    end

    // Storage with per-byte write enables and a registered read port; no
    // reset so contents survive reset and the array maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (commit_s && !err_s) begin
            if (cur_write_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en_s[i]) begin
                        mem_q[word_idx_s][8*i +: 8] <= store_word_s[8*i +: 8];
                    end
                end
            end else begin
                raw_q <= mem_q[word_idx_s];
            end
        end
    end

    assign bus.ReqReady  = (state_q == ST_IDLE) && Rst;
    assign bus.RespValid = (state_q == ST_RESP);
    assign bus.RespErr   = (state_q == ST_RESP) && resp_err_q;
    assign bus.RespRData = ((state_q == ST_RESP) && !resp_err_q && !req_write_q)
                         ? load_data_s : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states and one with none,
// driven through the shared bus interface.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .Clk(clk), .Rst(rst_n), .bus(bus2)
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Rst(rst_n), .bus(bus0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request on bus2 and let it be accepted; afterwards the bus
    // fields are scrambled so the responder must use its captured copy.
    task automatic issue2(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn);
        @(negedge clk);
        bus2.ReqWrite  = wr;
        bus2.ReqAddr   = addr;
        bus2.ReqWData  = wdata;
        bus2.ReqSize   = size;
        bus2.ReqSigned = sgn;
        bus2.ReqValid  = 1'b1;
        check_eq("req_ready_idle", 32'(bus2.ReqReady), 32'd1);
        @(posedge clk);
        #1;
        bus2.ReqValid = 1'b0;
        bus2.ReqWrite = ~wr;
        bus2.ReqAddr  = 32'h0000_0024;
        bus2.ReqWData = 32'hFFFF_FFFF;
        bus2.ReqSize  = SIZE_WORD;
    endtask

    // Cycles from the accept edge until RespValid is seen, bounded.
    task automatic wait_resp2(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus2.RespValid && lat < 20);
        if (!bus2.RespValid) check_eq("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume2();
        bus2.RespReady = 1'b1;
        @(posedge clk);
        #1;
        bus2.RespReady = 1'b0;
    endtask

    task automatic xact2(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                         input logic [31:0] exp_data, input logic exp_err);
        int lat;
        issue2(wr, addr, wdata, size, sgn);
        wait_resp2(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        check_eq({tag, "_data"}, bus2.RespRData, exp_data);
        check_eq({tag, "_err"}, 32'(bus2.RespErr), 32'(exp_err));
        consume2();
    endtask

    initial begin
        int lat;
        bus2.ReqValid = 1'b0; bus2.ReqWrite = 1'b0; bus2.ReqAddr = 32'h0;
        bus2.ReqWData = 32'h0; bus2.ReqSize = SIZE_WORD; bus2.ReqSigned = 1'b0;
        bus2.RespReady = 1'b0;
        bus0.ReqValid = 1'b0; bus0.ReqWrite = 1'b0; bus0.ReqAddr = 32'h0;
        bus0.ReqWData = 32'h0; bus0.ReqSize = SIZE_WORD; bus0.ReqSigned = 1'b0;
        bus0.RespReady = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_resp_valid", 32'(bus2.RespValid), 32'd0);
        check_eq("rst_resp_err", 32'(bus2.RespErr), 32'd0);
        check_eq("rst_resp_rdata", bus2.RespRData, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_req_ready", 32'(bus2.ReqReady), 32'd1);
        check_eq("rel_req_ready0", 32'(bus0.ReqReady), 32'd1);

        // Basic word / byte / half traffic with two wait states
        xact2("st_w0",     1'b1, 32'h0000_0000, 32'h0123_4567, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        xact2("st_w10",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        xact2("ld_w10",    1'b0, 32'h0000_0010, 32'h0,         SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xact2("st_b11",    1'b1, 32'h0000_0011, 32'h0000_005A, SIZE_BYTE, 1'b0, 32'h0, 1'b0);
        xact2("ld_w10b",   1'b0, 32'h0000_0010, 32'h0,         SIZE_WORD, 1'b0, 32'hDE5A_BEEF, 1'b0);
        xact2("ld_bs10",   1'b0, 32'h0000_0010, 32'h0,         SIZE_BYTE, 1'b1, 32'hFFFF_FFDE, 1'b0);
        xact2("ld_bu10",   1'b0, 32'h0000_0010, 32'h0,         SIZE_BYTE, 1'b0, 32'h0000_00DE, 1'b0);
        xact2("ld_bs11",   1'b0, 32'h0000_0011, 32'h0,         SIZE_BYTE, 1'b1, 32'h0000_005A, 1'b0);
        xact2("ld_hs12",   1'b0, 32'h0000_0012, 32'h0,         SIZE_HALF, 1'b1, 32'hFFFF_BEEF, 1'b0);
        xact2("ld_hu10",   1'b0, 32'h0000_0010, 32'h0,         SIZE_HALF, 1'b0, 32'h0000_DE5A, 1'b0);
        xact2("ld_h13",    1'b0, 32'h0000_0013, 32'h0,         SIZE_HALF, 1'b1, 32'h0, 1'b1);
        xact2("ld_w12",    1'b0, 32'h0000_0012, 32'h0,         SIZE_WORD, 1'b0, 32'h0, 1'b1);
        xact2("ld_ill",    1'b0, 32'h0000_0010, 32'h0,         SIZE_ILLEGAL, 1'b0, 32'h0, 1'b1);
        xact2("st_oor",    1'b1, 32'h0000_1000, 32'hBAD0_BAD0, SIZE_WORD, 1'b0, 32'h0, 1'b1);
        xact2("ld_w0",     1'b0, 32'h0000_0000, 32'h0,         SIZE_WORD, 1'b0, 32'h0123_4567, 1'b0);
        xact2("st_h12",    1'b1, 32'h0000_0012, 32'h0000_CAFE, SIZE_HALF, 1'b0, 32'h0, 1'b0);
        xact2("ld_w10c",   1'b0, 32'h0000_0010, 32'h0,         SIZE_WORD, 1'b0, 32'hDE5A_CAFE, 1'b0);
        xact2("ld_bu13",   1'b0, 32'h0000_0013, 32'h0,         SIZE_BYTE, 1'b0, 32'h0000_00FE, 1'b0);

        // Backpressure: response held, second request waits for IDLE
        issue2(1'b0, 32'h0000_0010, 32'h0, SIZE_WORD, 1'b0);
        wait_resp2(lat);
        check_eq("bp_lat", 32'(lat), 32'd3);
        bus2.ReqWrite = 1'b0; bus2.ReqAddr = 32'h0000_0000; bus2.ReqSize = SIZE_WORD;
        bus2.ReqSigned = 1'b0; bus2.ReqValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(bus2.RespValid), 32'd1);
            check_eq("bp_rdata", bus2.RespRData, 32'hDE5A_CAFE);
            check_eq("bp_ready", 32'(bus2.ReqReady), 32'd0);
        end
        bus2.RespReady = 1'b1;
        @(posedge clk);
        #1;
        bus2.RespReady = 1'b0;
        @(negedge clk);
        check_eq("bp_idle_ready", 32'(bus2.ReqReady), 32'd1);
        check_eq("bp_idle_valid", 32'(bus2.RespValid), 32'd0);
        @(posedge clk);
        #1;
        bus2.ReqValid = 1'b0;
        wait_resp2(lat);
        check_eq("bp2_lat", 32'(lat), 32'd3);
        check_eq("bp2_rdata", bus2.RespRData, 32'h0123_4567);
        consume2();

        // Reset during WAIT of a store: aborted, memory keeps old value
        xact2("st_w20", 1'b1, 32'h0000_0020, 32'hAAAA_5555, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        issue2(1'b1, 32'h0000_0020, 32'h1111_1111, SIZE_WORD, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rw_valid", 32'(bus2.RespValid), 32'd0);
        check_eq("rw_err", 32'(bus2.RespErr), 32'd0);
        check_eq("rw_rdata", bus2.RespRData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rw_rel_ready", 32'(bus2.ReqReady), 32'd1);
        check_eq("rw_rel_valid", 32'(bus2.RespValid), 32'd0);
        xact2("ld_w20", 1'b0, 32'h0000_0020, 32'h0, SIZE_WORD, 1'b0, 32'hAAAA_5555, 1'b0);

        // Reset while a response is pending clears it immediately
        issue2(1'b0, 32'h0000_0010, 32'h0, SIZE_WORD, 1'b0);
        wait_resp2(lat);
        check_eq("rr_pre_rdata", bus2.RespRData, 32'hDE5A_CAFE);
        rst_n = 1'b0;
        #1;
        check_eq("rr_valid", 32'(bus2.RespValid), 32'd0);
        check_eq("rr_rdata", bus2.RespRData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xact2("ld_w10d", 1'b0, 32'h0000_0010, 32'h0, SIZE_WORD, 1'b0, 32'hDE5A_CAFE, 1'b0);

        // Zero wait states: back-to-back requests, one accept per 2 cycles
        @(negedge clk);
        bus0.ReqWrite = 1'b1; bus0.ReqAddr = 32'h0000_0004; bus0.ReqWData = 32'h1122_3344;
        bus0.ReqSize = SIZE_WORD; bus0.ReqSigned = 1'b0; bus0.ReqValid = 1'b1;
        bus0.RespReady = 1'b1;
        check_eq("z_ready0", 32'(bus0.ReqReady), 32'd1);
        check_eq("z_valid0", 32'(bus0.RespValid), 32'd0);
        @(negedge clk);
        check_eq("z_st_valid", 32'(bus0.RespValid), 32'd1);
        check_eq("z_st_ready", 32'(bus0.ReqReady), 32'd0);
        check_eq("z_st_err", 32'(bus0.RespErr), 32'd0);
        check_eq("z_st_rdata", bus0.RespRData, 32'h0);
        bus0.ReqWrite = 1'b0; bus0.ReqWData = 32'h0;
        @(negedge clk);
        check_eq("z_ready1", 32'(bus0.ReqReady), 32'd1);
        check_eq("z_valid1", 32'(bus0.RespValid), 32'd0);
        @(negedge clk);
        check_eq("z_ld_valid", 32'(bus0.RespValid), 32'd1);
        check_eq("z_ld_rdata", bus0.RespRData, 32'h1122_3344);
        check_eq("z_ld_ready", 32'(bus0.ReqReady), 32'd0);
        bus0.ReqAddr = 32'h0000_0006; bus0.ReqSize = SIZE_HALF;
        @(negedge clk);
        check_eq("z_ready2", 32'(bus0.ReqReady), 32'd1);
        @(negedge clk);
        check_eq("z_lh_valid", 32'(bus0.RespValid), 32'd1);
        check_eq("z_lh_rdata", bus0.RespRData, 32'h0000_3344);
        bus0.ReqValid = 1'b0;
        @(negedge clk);
        check_eq("z_end_valid", 32'(bus0.RespValid), 32'd0);
        bus0.RespReady = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
